// File: rtl/usb_txn_sequencer_if.sv
// Packet-engine bus between the transaction sequencer and the shared
// encoder / receiver. The sequencer is the master; the engines are the slave.
interface usb_txn_sequencer_if;
    logic       tx_start;
    logic [2:0] tx_kind;
    logic       tx_payload_sel;
    logic       tx_finished;
    logic       rx_enable;
    logic       rx_valid;
    logic [3:0] rx_pid;
    logic       rx_error;

    modport master (
        output tx_start,
        output tx_kind,
        output tx_payload_sel,
        output rx_enable,
        input  tx_finished,
        input  rx_valid,
        input  rx_pid,
        input  rx_error
    );

    modport slave (
        input  tx_start,
        input  tx_kind,
        input  tx_payload_sel,
        input  rx_enable,
        output tx_finished,
        output rx_valid,
        output rx_pid,
        output rx_error
    );
endinterface

// File: rtl/usb_txn_sequencer.sv
// USB host transaction sequencer: drives the shared packet encoder and the
// receiver through READ (OUT,DATA0,IN,DATA0) and WRITE (OUT,DATA0,OUT,DATA0)
// transactions with handshake checking, a receive timeout and per-phase retry.
module usb_txn_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 8,
    parameter int TIMER_W        = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       is_read,
    output logic                       busy,
    output logic                       done,
    output logic                       success,
    output logic [3:0]                 attempt,
    usb_txn_sequencer_if.master        bus
);

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_DATA0 = 4'b0011;

    localparam logic [2:0] KIND_OUT   = 3'd0;
    localparam logic [2:0] KIND_IN    = 3'd1;
    localparam logic [2:0] KIND_DATA0 = 3'd2;
    localparam logic [2:0] KIND_ACK   = 3'd3;

    localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         ATTEMPT_LAST = 4'(MAX_RETRY - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_P1_TOK,
        S_P1_DAT,
        S_P1_HS,
        S_P2_TOK,
        S_P2_DAT,
        S_P2_HS,
        S_P2_RX,
        S_P2_ACK,
        S_FINISH
    } state_t;

    state_t             state_q,   state_d;
    logic               tx_start_q, tx_start_d;
    logic               is_read_q,  is_read_d;
    logic               success_q,  success_d;
    logic [3:0]         attempt_q,  attempt_d;
    logic [TIMER_W-1:0] timer_q,    timer_d;

    logic in_tx;
    logic in_wait;
    logic tx_complete;
    logic timed_out;
    logic hs_ack;
    logic rx_data0;
    logic do_retry;
    logic retry_phase2;

    // State, encoder request and bookkeeping registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tx_start_q <= 1'b0;
            is_read_q  <= 1'b0;
            success_q  <= 1'b0;
            attempt_q  <= 4'd0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            is_read_q  <= is_read_d;
            success_q  <= success_d;
            attempt_q  <= attempt_d;
            timer_q    <= timer_d;
        end
    end

    // Next-state logic: transmit handshaking, wait-state timing and retry decisions
    always_comb begin
        state_d      = state_q;
        tx_start_d   = tx_start_q;
        is_read_d    = is_read_q;
        success_d    = success_q;
        attempt_d    = attempt_q;
        timer_d      = '0;
        do_retry     = 1'b0;
        retry_phase2 = 1'b0;

        in_tx = (state_q == S_P1_TOK) || (state_q == S_P1_DAT) ||
                (state_q == S_P2_TOK) || (state_q == S_P2_DAT) ||
                (state_q == S_P2_ACK);
        in_wait = (state_q == S_P1_HS) || (state_q == S_P2_HS) ||
                  (state_q == S_P2_RX);
        tx_complete = tx_start_q && bus.tx_finished;
        timed_out   = (timer_q == TIMER_LAST);
        hs_ack      = bus.rx_valid && !bus.rx_error && (bus.rx_pid == PID_ACK);
        rx_data0    = bus.rx_valid && !bus.rx_error && (bus.rx_pid == PID_DATA0);

        // A transmit state keeps requesting until the encoder finishes; when a
        // transmit state follows another, the request re-rises one cycle later.
        if (in_tx) begin
            tx_start_d = !tx_complete;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_P1_TOK;
                    tx_start_d = 1'b1;
                    is_read_d  = is_read;
                    success_d  = 1'b0;
                    attempt_d  = 4'd0;
                end
            end
            S_P1_TOK: if (tx_complete) state_d = S_P1_DAT;
            S_P1_DAT: if (tx_complete) state_d = S_P1_HS;
            S_P1_HS: begin
                if (bus.rx_valid) begin
                    if (hs_ack) begin
                        state_d    = S_P2_TOK;
                        tx_start_d = 1'b1;
                        attempt_d  = 4'd0;
                    end else begin
                        do_retry = 1'b1;
                    end
                end else if (timed_out) begin
                    do_retry = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_P2_TOK: begin
                if (tx_complete) begin
                    state_d = is_read_q ? S_P2_RX : S_P2_DAT;
                end
            end
            S_P2_DAT: if (tx_complete) state_d = S_P2_HS;
            S_P2_HS: begin
                retry_phase2 = 1'b1;
                if (bus.rx_valid) begin
                    if (hs_ack) begin
                        state_d   = S_FINISH;
                        success_d = 1'b1;
                        attempt_d = 4'd0;
                    end else begin
                        do_retry = 1'b1;
                    end
                end else if (timed_out) begin
                    do_retry = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_P2_RX: begin
                retry_phase2 = 1'b1;
                if (bus.rx_valid) begin
                    if (rx_data0) begin
                        state_d    = S_P2_ACK;
                        tx_start_d = 1'b1;
                        attempt_d  = 4'd0;
                    end else begin
                        do_retry = 1'b1;
                    end
                end else if (timed_out) begin
                    do_retry = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_P2_ACK: begin
                if (tx_complete) begin
                    state_d   = S_FINISH;
                    success_d = 1'b1;
                    attempt_d = 4'd0;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // The last allowed attempt ends the transaction as a failure;
        // otherwise the phase restarts from its token packet.
        if (do_retry) begin
            if (attempt_q == ATTEMPT_LAST) begin
                state_d   = S_FINISH;
                success_d = 1'b0;
            end else begin
                attempt_d  = attempt_q + 4'd1;
                state_d    = retry_phase2 ? S_P2_TOK : S_P1_TOK;
                tx_start_d = 1'b1;
            end
        end
    end

    // Output decode from the registered state
    always_comb begin
        bus.tx_kind        = KIND_OUT;
        bus.tx_payload_sel = 1'b0;
        case (state_q)
            S_P1_DAT: bus.tx_kind = KIND_DATA0;
            S_P2_TOK: bus.tx_kind = is_read_q ? KIND_IN : KIND_OUT;
            S_P2_DAT: begin
                bus.tx_kind        = KIND_DATA0;
                bus.tx_payload_sel = 1'b1;
            end
            S_P2_ACK: bus.tx_kind = KIND_ACK;
            default:  bus.tx_kind = KIND_OUT;
        endcase
        bus.tx_start  = tx_start_q;
        bus.rx_enable = (state_q == S_P1_HS) || (state_q == S_P2_HS) ||
                        (state_q == S_P2_RX);
        busy    = (state_q != S_IDLE) && (state_q != S_FINISH);
        done    = (state_q == S_FINISH);
        success = success_q;
        attempt = attempt_q;
    end

endmodule

// File: doc/usb_txn_sequencer.md
Name: usb_txn_sequencer

Overview:
- Transaction-level controller for the USB host.
- Sequences the shared packet encoder (token / DATA0 / handshake transmit) and the packet receiver through complete READ (OUT→DATA0→IN→DATA0) and WRITE (OUT→DATA0→OUT→DATA0) transactions.
- Applies handshake checking, timeouts and per-phase retries.
- Sits between the host read/write tasks and the wire-level packet engines; owns the encoder start/finished handshake so only one packet drives the bus at a time.

Parameters:
- TIMEOUT_CYCLES, 255: idle cycles waiting for a receiver packet before a phase counts as failed.
- MAX_RETRY, 8: attempts allowed per phase, including the first attempt.
- TIMER_W, 8: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request transaction; accepted only in IDLE
- is_read  input  1  1 = READ, 0 = WRITE; sampled with an accepted start
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  one-cycle completion pulse
- success  output  1  result; valid with done, held until the next accepted start
- tx_start  output  1  level request to the encoder
- tx_kind  output  3  0 OUT token, 1 IN token, 2 DATA0, 3 ACK; stable while tx_start is high
- tx_payload_sel  output  1  DATA0 payload: 0 mempage, 1 data
- tx_finished  input  1  encoder completion, level
- rx_enable  output  1  receiver armed
- rx_valid  input  1  one-cycle pulse: packet received
- rx_pid  input  4  received PID: ACK 4'b0010, NAK 4'b1010, DATA0 4'b0011
- rx_error  input  1  CRC/stuffing/EOP error; qualified by rx_valid
- attempt  output  4  current phase attempt number, 0-based

Behaviour:
- Reset (synchronous, takes priority over everything, including mid-transaction): state IDLE.
  - busy, done, success, tx_start, rx_enable, attempt = 0.
  - tx_kind = 0, tx_payload_sel = 0.
  - Timer cleared.
- States:
  - IDLE
  - P1_TOK, P1_DAT, P1_HS
  - P2_TOK, P2_DAT, P2_HS (write)
  - P2_RX, P2_ACK (read)
  - FINISH
- Transmit states:
  - tx_start is driven high on entry and held until tx_finished is seen high.
  - tx_start drops on the next cycle.
  - The next tx_start rises no sooner than 1 cycle later, giving at least 1 low cycle so the encoder rearms.
- Phase 1 (both transaction types):
  - P1_TOK sends OUT.
  - P1_DAT sends DATA0 with tx_payload_sel = 0.
  - P1_HS follows.
- WRITE phase 2: P2_TOK sends OUT, then P2_DAT sends DATA0 with tx_payload_sel = 1, then P2_HS.
- READ phase 2: P2_TOK sends IN, then P2_RX.
- Wait states (P1_HS, P2_HS, P2_RX):
  - rx_enable = 1 and the timer clears on entry.
  - The timer increments each cycle without rx_valid.
  - Timeout fires when timer == TIMEOUT_CYCLES-1.
- HS states:
  - rx_valid && !rx_error && rx_pid == ACK → next phase (P1→P2_TOK; P2_HS→FINISH with success = 1).
  - Any other rx_valid (NAK, error, unexpected PID), or timeout → retry.
- P2_RX:
  - rx_valid && !rx_error && rx_pid == DATA0 → P2_ACK, which sends ACK, then FINISH with success = 1.
  - Anything else, or timeout → retry; no ACK is sent.
- Retry:
  - If attempt == MAX_RETRY-1 → FINISH with success = 0.
  - Otherwise attempt++ and return to the phase token state (P1_TOK or P2_TOK).
  - attempt clears whenever a phase advances.
- Simultaneous events: rx_valid wins over timeout in the same cycle. rx_valid outside a wait state is ignored.
- FINISH: done = 1 for one cycle, busy = 0, then IDLE. rx_enable is low outside wait states.
- start while busy is ignored. start in IDLE accepts on the same edge; tx_start rises on the next cycle.
- Latency, WRITE, no retries: transaction ends 2 cycles after the second ACK rx_valid (FINISH then IDLE).

Test Plan:
- WRITE, device ACKs each phase after 10 cycles → tx_kind sequence 0,2,0,2; payload_sel 0 then 1; done with success = 1; attempt stays 0.
- READ, device returns ACK then DATA0 → tx_kind sequence 0,2,1,3; done with success = 1; no handshake sent before DATA0 arrives.
- P1 handshake NAK twice, then ACK → P1_TOK/P1_DAT resent; attempt goes 0→1→2→0; success = 1.
- No response in P2_RX, TIMEOUT_CYCLES = 255 → 8 IN tokens each 255 cycles apart; done with success = 0; ACK never sent.
- DATA0 with rx_error = 1 and a timeout-coincident rx_valid ACK in P1_HS → error retries the phase; coincident ACK is accepted, not treated as a timeout.
- reset asserted while tx_start is high in P2_DAT → next cycle all outputs 0, state IDLE; a new start completes normally.
